// File: rtl/i2c_line_conditioner.sv
// Synchronises and de-glitches raw I2C SCL/SDA, detects START/STOP conditions,
// tracks bus occupancy and flags SCL held low too long while the bus is busy.
module i2c_line_conditioner #(
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic sclIn,
    input  logic sdaIn,
    input  logic clrTimeout,
    output logic sclFilt,
    output logic sdaFilt,
    output logic startStrobe,
    output logic stopStrobe,
    output logic busBusy,
    output logic sclTimeout
);

    localparam int unsigned   TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0]    FILT_LAST = 4'(FILT_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } bus_state_e;

    // Bit 0 carries SCL, bit 1 carries SDA throughout.
    logic [1:0]      s1_q;
    logic [1:0]      s2_q;
    logic [1:0]      filt_q;
    logic [1:0]      filt_d;
    logic [1:0]      filt_prev_q;
    logic [1:0][3:0] fcnt_q;
    logic [1:0][3:0] fcnt_d;

    logic            start_q;
    logic            stop_q;
    logic            start_det;
    logic            stop_det;

    bus_state_e      state_q;
    bus_state_e      state_d;

    logic [TW-1:0]   tcnt_q;
    logic [TW-1:0]   tcnt_d;
    logic            to_active;
    logic            to_hit;
    logic            tflag_q;
    logic            tflag_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= '1;
            s2_q        <= '1;
            filt_q      <= '1;
            filt_prev_q <= '1;
            fcnt_q      <= '0;
        end else begin
            s1_q        <= {sdaIn, sclIn};
            s2_q        <= s1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            fcnt_q      <= fcnt_d;
        end
    end

    // A new level is adopted only after FILT_LEN consecutive disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (s2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FILT_LAST) begin
                    filt_d[i] = s2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 4'd1;
                end
            end
        end
    end

    // SCL must be high and stable on both cycles, so simultaneous changes never qualify.
    assign start_det = filt_prev_q[1] & ~filt_q[1] & filt_prev_q[0] & filt_q[0];
    assign stop_det  = ~filt_prev_q[1] & filt_q[1] & filt_prev_q[0] & filt_q[0];

    assign to_active = (state_q == BUSY) & ~filt_q[0];
    assign to_hit    = to_active & (tcnt_q == TO_LAST);

    always_comb begin
        tcnt_d = '0;
        if (to_active && !to_hit) begin
            tcnt_d = tcnt_q + TW'(1);
        end
    end

    always_comb begin
        tflag_d = tflag_q;
        if (to_hit) begin
            tflag_d = 1'b1;
        end else if (clrTimeout) begin
            tflag_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_det) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (to_hit || stop_det) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            tflag_q <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            tflag_q <= tflag_d;
            start_q <= start_det;
            stop_q  <= stop_det;
        end
    end

    assign sclFilt     = filt_q[0];
    assign sdaFilt     = filt_q[1];
    assign startStrobe = start_q;
    assign stopStrobe  = stop_q;
    assign busBusy     = (state_q == BUSY);
    assign sclTimeout  = tflag_q;

endmodule

// File: doc/i2c_line_conditioner.md
# i2c_line_conditioner

Synchronises and de-glitches the raw I2C SCL/SDA pins into the FPGA clock domain and detects START/STOP conditions. It also tracks bus occupancy and flags an SCL-stuck-low timeout. It sits directly upstream of the I2C slave register block: the slave consumes `sclFilt` and `sdaFilt` as clean line levels, and `busBusy` and `sclTimeout` feed the bus-recovery and status logic.

## Interface
- `FILT_LEN`, 4: consecutive `clk` cycles a new synchronised level must persist before the filtered output follows it. Legal range 1..15.
- `TIMEOUT_CYC`, 100000: cycles of `sclFilt` low while `busBusy` that trigger a timeout (1 ms at 100 MHz). Must be ≥ 2.
- `clk` in 1: system clock.
- `rst` in 1: reset; asynchronous, active-high.
- `sclIn` in 1: raw SCL pin level, asynchronous.
- `sdaIn` in 1: raw SDA pin level, asynchronous.
- `clrTimeout` in 1: single-cycle pulse that clears `sclTimeout`.
- `sclFilt` out 1: synchronised, filtered SCL.
- `sdaFilt` out 1: synchronised, filtered SDA.
- `startStrobe` out 1: one-cycle pulse on START or repeated START.
- `stopStrobe` out 1: one-cycle pulse on STOP.
- `busBusy` out 1: high between START and STOP/timeout.
- `sclTimeout` out 1: sticky SCL-stuck-low flag.

## Operation
- **Reset values.** `sclFilt`=1, `sdaFilt`=1, `startStrobe`=0, `stopStrobe`=0, `busBusy`=0, `sclTimeout`=0. All internal sync flops reset to 1; all counters reset to 0. Assertion mid-transfer takes effect immediately (asynchronous).
- **Synchroniser.** Two flops per line, giving `s1` then `s2`.
- **Filter, per line.**
  - Keeps a 4-bit counter.
  - If `s2` ≠ filtered output: the counter increments.
  - When the increment would reach `FILT_LEN`: the filtered output takes `s2` and the counter clears.
  - Any cycle with `s2` equal to the filtered output clears the counter.
  - Consequence: pulses shorter than `FILT_LEN` cycles (after synchronisation) are fully suppressed.
- **Edge detect.** Registered copies `sclFiltD` and `sdaFiltD` hold the previous-cycle values.
  - START: `sdaFiltD`=1, `sdaFilt`=0, `sclFiltD`=1, `sclFilt`=1.
  - STOP: `sdaFiltD`=0, `sdaFilt`=1, `sclFiltD`=1, `sclFilt`=1.
  - If SCL and SDA filtered outputs change in the same cycle, neither strobe fires. The event is treated as a data transition.
  - Strobes are registered, are high for exactly one cycle, and never both high at once.
- **Bus state.** Two states, IDLE (`busBusy`=0) and BUSY (`busBusy`=1).
  - IDLE → BUSY on START.
  - BUSY → BUSY on START (repeated START; no other effect).
  - BUSY → IDLE on STOP, or on timeout.
  - STOP while IDLE: `stopStrobe` still pulses; the state stays IDLE.
- **Timeout counter.**
  - Increments each cycle that `busBusy`=1 and `sclFilt`=0.
  - Clears when `sclFilt`=1 or `busBusy`=0.
  - Saturates at `TIMEOUT_CYC`.
  - On the cycle the count reaches `TIMEOUT_CYC`: `sclTimeout` sets, `busBusy` clears, and the counter clears.
  - Width is ceil(log2(`TIMEOUT_CYC`+1)).
- **`sclTimeout`.** Sticky; cleared only by `clrTimeout` or `rst`. If `clrTimeout` coincides with a new timeout event, set wins.
- **START while `sclTimeout`=1.** Enters BUSY normally; the flag stays set until cleared.

## Timing
- **Raw edge to filtered output.** A raw level stable from sampling edge n appears on `s2` after edge n+1. The filtered output updates at edge n+1+`FILT_LEN`. Latency is `FILT_LEN`+2 clocks.
- **Filtered edge to strobe.** `startStrobe`/`stopStrobe` rise at the edge following the qualifying filtered-output change and fall one edge later.
- **Bus state.** `busBusy` changes on the same edge the strobe rises.
- **Timeout.** `sclTimeout` rises on the edge where the count reaches `TIMEOUT_CYC`. This is `TIMEOUT_CYC` edges after the first cycle with `busBusy`=1 and `sclFilt`=0.
- **Maximum SCL rate.** A minimum SCL high/low time of `FILT_LEN`+2 `clk` periods is required. This is ample margin for 400 kHz at 100 MHz.

## Test plan
- **Reset.** Assert `rst` with the lines at 0, release after 3 cycles, lines held at 1 → all outputs at reset values. `sclFilt`/`sdaFilt` stay 1 with no strobe.
- **Glitch rejection (`FILT_LEN`=4).**
  - 3-cycle low pulse on `sclIn` → `sclFilt` stays 1.
  - 4-cycle low pulse → `sclFilt` low for 4 cycles, starting 6 cycles after the pulse starts.
- **START/STOP.**
  - `sdaIn` falls with `sclIn`=1 → single `startStrobe` 7 cycles later, `busBusy`=1.
  - Later, `sdaIn` rises with `sclIn`=1 → single `stopStrobe`, `busBusy`=0.
- **Simultaneous change.** `sclIn` and `sdaIn` fall on the same cycle → no strobes, `busBusy` unchanged.
- **Timeout (`TIMEOUT_CYC`=50).**
  - START, then hold `sclIn`=0 → `sclTimeout`=1 and `busBusy`=0 exactly 50 cycles after `sclFilt` falls.
  - `clrTimeout` pulse → `sclTimeout`=0.
  - Repeat with `clrTimeout` on the trigger cycle → flag stays 1.
- **Repeated START and reset mid-transfer.**
  - START, data bits, repeated START → second `startStrobe`, `busBusy` stays 1.
  - Assert `rst` mid-byte → `busBusy`=0 and filtered outputs=1 immediately.
